// File: rtl/dram_bank_timing_tracker_if.sv
// Scheduler-to-tracker bus: the issued command, a candidate command to
// query, and the tracker's legality, bank-status and refresh responses.
interface dram_bank_timing_tracker_if #(
  parameter int BG_WIDTH   = 2,
  parameter int BANK_WIDTH = 2,
  parameter int ROW_WIDTH  = 15
) ();
  logic                  cmd_valid;
  logic [2:0]            cmd_opcode;
  logic [BG_WIDTH-1:0]   cmd_bg;
  logic [BANK_WIDTH-1:0] cmd_bank;
  logic [ROW_WIDTH-1:0]  cmd_row;
  logic [2:0]            chk_opcode;
  logic [BG_WIDTH-1:0]   chk_bg;
  logic [BANK_WIDTH-1:0] chk_bank;
  logic [ROW_WIDTH-1:0]  chk_row;
  logic                  chk_legal;
  logic                  chk_bank_open;
  logic                  chk_row_hit;
  logic                  refresh_due;
  logic                  cmd_illegal;

  modport master (
    output cmd_valid, cmd_opcode, cmd_bg, cmd_bank, cmd_row,
    output chk_opcode, chk_bg, chk_bank, chk_row,
    input  chk_legal, chk_bank_open, chk_row_hit, refresh_due, cmd_illegal
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_bg, cmd_bank, cmd_row,
    input  chk_opcode, chk_bg, chk_bank, chk_row,
    output chk_legal, chk_bank_open, chk_row_hit, refresh_due, cmd_illegal
  );
endinterface

// File: rtl/dram_bank_timing_tracker.sv
// Per-bank open/row state plus intra-bank, inter-bank and refresh timing
// countdowns for the DDR4 scheduler; answers legality queries combinationally.
module dram_bank_timing_tracker #(
  parameter int BG_WIDTH   = 2,
  parameter int BANK_WIDTH = 2,
  parameter int ROW_WIDTH  = 15,
  parameter int T_RC       = 152,
  parameter int T_RAS      = 104,
  parameter int T_RP       = 48,
  parameter int T_RCD      = 48,
  parameter int T_RRD_L    = 12,
  parameter int T_RRD_S    = 8,
  parameter int T_CCD_L    = 16,
  parameter int T_CCD_S    = 8,
  parameter int T_RTP      = 24,
  parameter int T_WTP      = 88,
  parameter int T_RFC      = 1120,
  parameter int T_REFI     = 24960
) (
  input logic clk,
  input logic rst,
  dram_bank_timing_tracker_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int IDX_W = BG_WIDTH + BANK_WIDTH;
  localparam int NB    = 1 << IDX_W;
  localparam int NG    = 1 << BG_WIDTH;
  localparam int T_MAX = max2(max2(max2(max2(T_RC, T_RAS), max2(T_RP, T_RCD)),
                                   max2(max2(T_RRD_L, T_RRD_S), max2(T_CCD_L, T_CCD_S))),
                              max2(max2(T_RTP, T_WTP), max2(T_RFC, T_REFI)));
  localparam int CW    = $clog2(T_MAX + 1);
  localparam int RW    = $clog2(T_REFI + 1);

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    OP_RD  = 3'd0,
    OP_WR  = 3'd1,
    OP_ACT = 3'd2,
    OP_PRE = 3'd3,
    OP_REF = 3'd4
  } opcode_e;

  logic [NB-1:0]        bank_open, bank_open_n;
  logic [ROW_WIDTH-1:0] open_row [NB];
  logic [ROW_WIDTH-1:0] open_row_n [NB];
  cnt_t                 act_cnt [NB];
  cnt_t                 act_cnt_n [NB];
  cnt_t                 cas_cnt [NB];
  cnt_t                 cas_cnt_n [NB];
  cnt_t                 pre_cnt [NB];
  cnt_t                 pre_cnt_n [NB];
  cnt_t                 rrd_l [NG];
  cnt_t                 rrd_l_n [NG];
  cnt_t                 ccd_l [NG];
  cnt_t                 ccd_l_n [NG];
  cnt_t                 rrd_s, rrd_s_n;
  cnt_t                 ccd_s, ccd_s_n;
  cnt_t                 rfc_cnt, rfc_cnt_n;
  logic [RW-1:0]        refi_cnt, refi_cnt_n;
  logic                 refresh_due_q, refresh_due_n;
  logic                 cmd_illegal_q;
  logic                 all_idle;
  logic                 cmd_accept;
  logic [IDX_W-1:0]     cmd_idx, chk_idx;

  function automatic cnt_t dec(input cnt_t d);
    return (d == '0) ? d : d - cnt_t'(1);
  endfunction

  // A new event can only lengthen an already-running window, never shorten it.
  function automatic cnt_t ld(input cnt_t d, input int t);
    cnt_t tv;
    tv = cnt_t'(t - 1);
    return (d > tv) ? d : tv;
  endfunction

  function automatic logic is_legal(input logic [2:0] op,
                                    input logic [IDX_W-1:0] idx,
                                    input logic [BG_WIDTH-1:0] bg,
                                    input logic [ROW_WIDTH-1:0] row);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ACT:
        ok = !bank_open[idx] && (act_cnt[idx] == '0) && (rrd_l[bg] == '0) &&
             (rrd_s == '0) && !refresh_due_q;
      OP_RD, OP_WR:
        ok = bank_open[idx] && (open_row[idx] == row) && (cas_cnt[idx] == '0) &&
             (ccd_l[bg] == '0) && (ccd_s == '0);
      OP_PRE:
        ok = bank_open[idx] && (pre_cnt[idx] == '0);
      OP_REF:
        ok = all_idle;
      default:
        ok = 1'b0;
    endcase
    return ok && (rfc_cnt == '0);
  endfunction

  assign cmd_idx = {bus.cmd_bg, bus.cmd_bank};
  assign chk_idx = {bus.chk_bg, bus.chk_bank};

  always_comb begin
    all_idle = (bank_open == '0);
    for (int i = 0; i < NB; i++) begin
      if (act_cnt[i] != '0) all_idle = 1'b0;
    end
  end

  assign cmd_accept = bus.cmd_valid &&
                      is_legal(bus.cmd_opcode, cmd_idx, bus.cmd_bg, bus.cmd_row);

  assign bus.chk_legal     = is_legal(bus.chk_opcode, chk_idx, bus.chk_bg, bus.chk_row);
  assign bus.chk_bank_open = bank_open[chk_idx];
  assign bus.chk_row_hit   = bank_open[chk_idx] && (open_row[chk_idx] == bus.chk_row);
  assign bus.refresh_due   = refresh_due_q;
  assign bus.cmd_illegal   = cmd_illegal_q;

  // Every countdown ages by one; an accepted command then stretches the
  // windows it opens. Rejected commands leave state untouched.
  always_comb begin
    bank_open_n = bank_open;
    for (int i = 0; i < NB; i++) begin
      open_row_n[i] = open_row[i];
      act_cnt_n[i]  = dec(act_cnt[i]);
      cas_cnt_n[i]  = dec(cas_cnt[i]);
      pre_cnt_n[i]  = dec(pre_cnt[i]);
    end
    for (int g = 0; g < NG; g++) begin
      rrd_l_n[g] = dec(rrd_l[g]);
      ccd_l_n[g] = dec(ccd_l[g]);
    end
    rrd_s_n       = dec(rrd_s);
    ccd_s_n       = dec(ccd_s);
    rfc_cnt_n     = dec(rfc_cnt);
    refi_cnt_n    = (refi_cnt == RW'(T_REFI)) ? refi_cnt : refi_cnt + RW'(1);
    refresh_due_n = (refi_cnt_n == RW'(T_REFI));

    if (cmd_accept) begin
      case (bus.cmd_opcode)
        OP_ACT: begin
          act_cnt_n[cmd_idx]  = ld(act_cnt_n[cmd_idx], T_RC);
          cas_cnt_n[cmd_idx]  = ld(cas_cnt_n[cmd_idx], T_RCD);
          pre_cnt_n[cmd_idx]  = ld(pre_cnt_n[cmd_idx], T_RAS);
          rrd_l_n[bus.cmd_bg] = ld(rrd_l_n[bus.cmd_bg], T_RRD_L);
          rrd_s_n             = ld(rrd_s_n, T_RRD_S);
          bank_open_n[cmd_idx] = 1'b1;
          open_row_n[cmd_idx]  = bus.cmd_row;
        end
        OP_RD: begin
          pre_cnt_n[cmd_idx]  = ld(pre_cnt_n[cmd_idx], T_RTP);
          ccd_l_n[bus.cmd_bg] = ld(ccd_l_n[bus.cmd_bg], T_CCD_L);
          ccd_s_n             = ld(ccd_s_n, T_CCD_S);
        end
        OP_WR: begin
          pre_cnt_n[cmd_idx]  = ld(pre_cnt_n[cmd_idx], T_WTP);
          ccd_l_n[bus.cmd_bg] = ld(ccd_l_n[bus.cmd_bg], T_CCD_L);
          ccd_s_n             = ld(ccd_s_n, T_CCD_S);
        end
        OP_PRE: begin
          act_cnt_n[cmd_idx]   = ld(act_cnt_n[cmd_idx], T_RP);
          bank_open_n[cmd_idx] = 1'b0;
        end
        OP_REF: begin
          rfc_cnt_n     = ld(rfc_cnt_n, T_RFC);
          refi_cnt_n    = '0;
          refresh_due_n = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_open     <= '0;
      open_row      <= '{default: '0};
      act_cnt       <= '{default: '0};
      cas_cnt       <= '{default: '0};
      pre_cnt       <= '{default: '0};
      rrd_l         <= '{default: '0};
      ccd_l         <= '{default: '0};
      rrd_s         <= '0;
      ccd_s         <= '0;
      rfc_cnt       <= '0;
      refi_cnt      <= '0;
      refresh_due_q <= 1'b0;
      cmd_illegal_q <= 1'b0;
    end else begin
      bank_open     <= bank_open_n;
      open_row      <= open_row_n;
      act_cnt       <= act_cnt_n;
      cas_cnt       <= cas_cnt_n;
      pre_cnt       <= pre_cnt_n;
      rrd_l         <= rrd_l_n;
      ccd_l         <= ccd_l_n;
      rrd_s         <= rrd_s_n;
      ccd_s         <= ccd_s_n;
      rfc_cnt       <= rfc_cnt_n;
      refi_cnt      <= refi_cnt_n;
      refresh_due_q <= refresh_due_n;
      cmd_illegal_q <= bus.cmd_valid && !cmd_accept;
    end
  end

endmodule

// File: tb/tb_dram_bank_timing_tracker.sv
// Scoreboard bench for dram_bank_timing_tracker: expectations are queued as
// each query is driven and compared when the DUT outputs are sampled.
module tb_dram_bank_timing_tracker;

  localparam int BGW  = 2;
  localparam int BKW  = 2;
  localparam int RWD  = 15;
  localparam logic [2:0] RD = 3'd0, WR = 3'd1, ACT = 3'd2, PRE = 3'd3, REF = 3'd4;
  localparam int SEL_LEGAL = 0, SEL_OPEN = 1, SEL_HIT = 2, SEL_DUE = 3, SEL_ILL = 4;

  typedef struct {
    string tag;
    int    sel;
    logic  exp;
  } sb_t;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;
  sb_t  sb_q[$];

  dram_bank_timing_tracker_if #(.BG_WIDTH(BGW), .BANK_WIDTH(BKW), .ROW_WIDTH(RWD)) bus ();

  dram_bank_timing_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic observe(input int sel);
    case (sel)
      SEL_LEGAL: return bus.chk_legal;
      SEL_OPEN:  return bus.chk_bank_open;
      SEL_HIT:   return bus.chk_row_hit;
      SEL_DUE:   return bus.refresh_due;
      default:   return bus.cmd_illegal;
    endcase
  endfunction

  task automatic pushExpect(input string tag, input int sel, input logic exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drainScoreboard();
    sb_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Drive a candidate query; open/hit checks are skipped when given as -1.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input int bg,
                               input int bank, input int row, input int exp_legal,
                               input int exp_open = -1, input int exp_hit = -1);
    bus.chk_opcode = op;
    bus.chk_bg     = BGW'(bg);
    bus.chk_bank   = BKW'(bank);
    bus.chk_row    = RWD'(row);
    pushExpect({tag, " legal"}, SEL_LEGAL, exp_legal[0]);
    if (exp_open >= 0) pushExpect({tag, " open"}, SEL_OPEN, exp_open[0]);
    if (exp_hit >= 0)  pushExpect({tag, " hit"}, SEL_HIT, exp_hit[0]);
    drainScoreboard();
  endtask

  task automatic checkFlag(input string tag, input int sel, input logic exp);
    pushExpect(tag, sel, exp);
    drainScoreboard();
  endtask

  task automatic issue(input logic [2:0] op, input int bg, input int bank, input int row);
    bus.cmd_opcode = op;
    bus.cmd_bg     = BGW'(bg);
    bus.cmd_bank   = BKW'(bank);
    bus.cmd_row    = RWD'(row);
    bus.cmd_valid  = 1'b1;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = RD;
    bus.cmd_bg     = '0;
    bus.cmd_bank   = '0;
    bus.cmd_row    = '0;
    bus.chk_opcode = RD;
    bus.chk_bg     = '0;
    bus.chk_bank   = '0;
    bus.chk_row    = '0;

    // 1: tRCD and row hit/miss
    $display("[TB] tRCD and row hit");
    doReset();
    checkFlag("reset refresh_due", SEL_DUE, 1'b0);
    checkFlag("reset cmd_illegal", SEL_ILL, 1'b0);
    applyStimulus("reset act b1/2", ACT, 1, 2, 0, 1, 0, 0);
    issue(ACT, 1, 2, 'h1234);
    for (int k = 1; k <= 48; k++) begin
      applyStimulus($sformatf("trcd rd t%0d", k), RD, 1, 2, 'h1234, (k >= 48) ? 1 : 0, 1, 1);
      if (k < 48) idle(1);
    end
    applyStimulus("row miss rd", RD, 1, 2, 'h1235, 0, 1, 0);
    applyStimulus("act open bank", ACT, 1, 2, 'h1234, 0);

    // 2: tRAS then tRP/tRC
    $display("[TB] tRAS / tRP / tRC");
    doReset();
    issue(ACT, 0, 0, 5);
    idle(102);
    applyStimulus("tras pre t103", PRE, 0, 0, 0, 0);
    idle(1);
    applyStimulus("tras pre t104", PRE, 0, 0, 0, 1);
    issue(PRE, 0, 0, 0);
    applyStimulus("after pre closed", ACT, 0, 0, 0, 0, 0, 0);
    idle(46);
    applyStimulus("trc act t151", ACT, 0, 0, 0, 0);
    idle(1);
    applyStimulus("trc act t152", ACT, 0, 0, 0, 1);

    // 3: tRRD_L / tRRD_S
    $display("[TB] tRRD");
    doReset();
    issue(ACT, 0, 0, 1);
    idle(6);
    applyStimulus("rrd_s t7", ACT, 1, 0, 0, 0);
    applyStimulus("rrd_l t7", ACT, 0, 1, 0, 0);
    idle(1);
    applyStimulus("rrd_s t8", ACT, 1, 0, 0, 1);
    applyStimulus("rrd_l t8", ACT, 0, 1, 0, 0);
    idle(3);
    applyStimulus("rrd_l t11", ACT, 0, 1, 0, 0);
    idle(1);
    applyStimulus("rrd_l t12", ACT, 0, 1, 0, 1);

    // 4: tCCD_L / tCCD_S / tRTP
    $display("[TB] tCCD and tRTP");
    doReset();
    issue(ACT, 0, 0, 10);
    idle(11);
    issue(ACT, 1, 0, 12);
    idle(11);
    issue(ACT, 0, 1, 11);
    idle(11);
    issue(ACT, 1, 1, 13);
    checkFlag("four acts accepted", SEL_ILL, 1'b0);
    idle(110);
    issue(RD, 0, 0, 10);
    checkFlag("rd accepted", SEL_ILL, 1'b0);
    idle(6);
    applyStimulus("ccd_s t+7", RD, 1, 0, 12, 0, 1, 1);
    idle(1);
    applyStimulus("ccd_s t+8", RD, 1, 0, 12, 1);
    applyStimulus("ccd_l t+8", RD, 0, 1, 11, 0);
    idle(7);
    applyStimulus("ccd_l t+15", RD, 0, 1, 11, 0);
    idle(1);
    applyStimulus("ccd_l t+16", RD, 0, 1, 11, 1);
    idle(7);
    applyStimulus("rtp pre t+23", PRE, 0, 0, 0, 0);
    idle(1);
    applyStimulus("rtp pre t+24", PRE, 0, 0, 0, 1);

    // 5: refresh interval, REF gating and tRFC
    $display("[TB] refresh");
    doReset();
    issue(ACT, 0, 3, 77);
    idle(24958);
    checkFlag("due edge 24959", SEL_DUE, 1'b0);
    applyStimulus("act before due", ACT, 1, 0, 0, 1);
    idle(1);
    checkFlag("due edge 24960", SEL_DUE, 1'b1);
    applyStimulus("act while due", ACT, 1, 0, 0, 0);
    applyStimulus("ref bank open", REF, 0, 0, 0, 0);
    issue(PRE, 0, 3, 0);
    applyStimulus("ref after pre", REF, 0, 0, 0, 0);
    idle(46);
    applyStimulus("ref pre+47", REF, 0, 0, 0, 0);
    idle(1);
    applyStimulus("ref pre+48", REF, 0, 0, 0, 1);
    checkFlag("due held", SEL_DUE, 1'b1);
    issue(REF, 0, 0, 0);
    checkFlag("due cleared", SEL_DUE, 1'b0);
    checkFlag("ref accepted", SEL_ILL, 1'b0);
    applyStimulus("rfc act r+1", ACT, 2, 1, 0, 0);
    applyStimulus("rfc ref r+1", REF, 0, 0, 0, 0);
    idle(1118);
    applyStimulus("rfc act r+1119", ACT, 2, 1, 0, 0);
    idle(1);
    applyStimulus("rfc act r+1120", ACT, 2, 1, 0, 1);

    // 6: illegal command pulse and asynchronous reset mid-operation
    $display("[TB] illegal command and async reset");
    doReset();
    issue(WR, 0, 0, 0);
    checkFlag("illegal pulse", SEL_ILL, 1'b1);
    applyStimulus("wr closed bank", WR, 0, 0, 0, 0, 0, 0);
    idle(1);
    checkFlag("illegal one cycle", SEL_ILL, 1'b0);
    issue(ACT, 0, 0, 7);
    idle(7);
    issue(ACT, 1, 2, 9);
    checkFlag("acts legal", SEL_ILL, 1'b0);
    applyStimulus("pre-reset open", RD, 1, 2, 9, 0, 1, 1);
    applyStimulus("pre-reset rrd", ACT, 1, 3, 0, 0);
    #3 rst = 1'b1;
    #3 rst = 1'b0;
    @(negedge clk);
    checkFlag("post-reset due", SEL_DUE, 1'b0);
    for (int b = 0; b < 16; b++) begin
      applyStimulus($sformatf("post-reset act %0d", b), ACT, b / 4, b % 4, 0, 1, 0);
      if (b == 7) @(negedge clk);
    end

    if (sb_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
